// File: rtl/stepper_pkg.sv
// rtl/stepper_pkg.sv - shared constants, phase table and helpers for the stepper motion controller
package stepper_pkg;

    localparam logic [2:0] ADDR_PWM_FREQ    = 3'd0;
    localparam logic [2:0] ADDR_PWM_DUTY    = 3'd1;
    localparam logic [2:0] ADDR_CTRL        = 3'd2;
    localparam logic [2:0] ADDR_STEP_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_STEP_COUNT  = 3'd4;
    localparam logic [2:0] ADDR_STATUS      = 3'd5;
    localparam logic [2:0] ADDR_CMD         = 3'd6;
    localparam logic [2:0] ADDR_POSITION    = 3'd7;

    localparam int CTRL_DIR    = 0;
    localparam int CTRL_HALF   = 1;
    localparam int CTRL_DRV_EN = 2;
    localparam int CTRL_HOLD   = 3;
    localparam int CTRL_IRQ_EN = 4;
    localparam int CTRL_W      = 5;

    localparam int STATUS_BUSY    = 0;
    localparam int STATUS_DONE    = 1;
    localparam int STATUS_IDX_LSB = 4;

    localparam int CMD_ABORT    = 0;
    localparam int CMD_CLR_DONE = 1;
    localparam int CMD_SINGLE   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Coil vector {A1, A2, B1, B2}; odd indices are the two-coil (full-step) states.
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };

    function automatic logic [2:0] next_phase(input logic [2:0] idx, input logic dir,
                                              input logic half_step);
        logic [2:0] delta;
        delta = (half_step || !idx[0]) ? 3'd1 : 3'd2;
        return dir ? idx + delta : idx - delta;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wdata,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? wdata[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/stepper_phase_seq.sv
// rtl/stepper_phase_seq.sv - phase index register and active-low coil pin drive
module stepper_phase_seq
    import stepper_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       dir,
    input  logic       half_step,
    output logic [2:0] idx,
    output logic       ax,
    output logic       ay,
    output logic       bx,
    output logic       by
);

    logic [3:0] coils;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (step) begin
            idx <= next_phase(idx, dir, half_step);
        end
    end

    // MSB of the coil vector (A1) lands on BY.
    assign coils = PHASE_TABLE[idx];
    assign {by, bx, ay, ax} = ~coils;

endmodule

// File: rtl/stepper_motion_ctrl.sv
// rtl/stepper_motion_ctrl.sv - Avalon-MM stepper controller: PWM chopper, timed moves, position tracking
module stepper_motion_ctrl
    import stepper_pkg::*;
#(
    parameter int PWM_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 32,
    parameter int COUNT_WIDTH  = 24,
    parameter int POS_WIDTH    = 32
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic        ins_irq_irq,
    output logic        AX,
    output logic        AY,
    output logic        BX,
    output logic        BY,
    output logic        AE,
    output logic        BE
);

    logic [PWM_WIDTH-1:0]    pwm_freq;
    logic [PWM_WIDTH-1:0]    pwm_duty;
    logic [PWM_WIDTH-1:0]    acc;
    logic                    pwm_on;
    logic [CTRL_W-1:0]       ctrl;
    logic [PERIOD_WIDTH-1:0] step_period;
    logic [PERIOD_WIDTH-1:0] timer;
    logic [PERIOD_WIDTH-1:0] timer_reload;
    logic [COUNT_WIDTH-1:0]  remaining;
    logic [COUNT_WIDTH-1:0]  count_val;
    logic [POS_WIDTH-1:0]    position;
    logic                    done;
    logic [2:0]              phase_idx;
    state_t                  state;
    state_t                  state_next;

    logic [31:0] rd_word;
    logic [31:0] wr_merged;
    logic        wr_freq, wr_duty, wr_ctrl, wr_period, wr_count, wr_cmd, wr_pos;
    logic        start, cmd_abort, cmd_clr_done, cmd_single;
    logic        busy, run_step, finish, single_fire, step;

    assign wr_freq   = avs_ctrl_write && (avs_ctrl_address == ADDR_PWM_FREQ);
    assign wr_duty   = avs_ctrl_write && (avs_ctrl_address == ADDR_PWM_DUTY);
    assign wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == ADDR_CTRL);
    assign wr_period = avs_ctrl_write && (avs_ctrl_address == ADDR_STEP_PERIOD);
    assign wr_count  = avs_ctrl_write && (avs_ctrl_address == ADDR_STEP_COUNT);
    assign wr_cmd    = avs_ctrl_write && (avs_ctrl_address == ADDR_CMD);
    assign wr_pos    = avs_ctrl_write && (avs_ctrl_address == ADDR_POSITION);

    // The read mux doubles as the old value for byte-lane merging on writes.
    assign wr_merged = be_merge(rd_word, avs_ctrl_writedata, avs_ctrl_byteenable);
    assign count_val = wr_merged[COUNT_WIDTH-1:0];

    assign start        = wr_count && (count_val != '0);
    assign cmd_abort    = wr_cmd && avs_ctrl_writedata[CMD_ABORT];
    assign cmd_clr_done = wr_cmd && avs_ctrl_writedata[CMD_CLR_DONE];
    assign cmd_single   = wr_cmd && avs_ctrl_writedata[CMD_SINGLE];

    // A period of 0 behaves as 1: one step per clock.
    assign timer_reload = (step_period == '0) ? '0 : step_period - PERIOD_WIDTH'(1);

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cmd_abort || finish) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Abort and a STEP_COUNT reload both swallow a step that falls due in the same cycle.
    always_comb begin
        busy        = (state == ST_RUN);
        run_step    = busy && (timer == '0) && !start && !cmd_abort;
        finish      = run_step && (remaining == COUNT_WIDTH'(1));
        single_fire = cmd_single && !busy;
        step        = run_step || single_fire;
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            pwm_freq          <= '0;
            pwm_duty          <= '0;
            acc               <= '0;
            pwm_on            <= 1'b0;
            ctrl              <= '0;
            step_period       <= '0;
            timer             <= '0;
            remaining         <= '0;
            position          <= '0;
            done              <= 1'b0;
            avs_ctrl_readdata <= '0;
        end else begin
            acc    <= acc + pwm_freq;
            pwm_on <= (acc <= pwm_duty);

            if (wr_freq)   pwm_freq    <= wr_merged[PWM_WIDTH-1:0];
            if (wr_duty)   pwm_duty    <= wr_merged[PWM_WIDTH-1:0];
            if (wr_ctrl)   ctrl        <= avs_ctrl_writedata[CTRL_W-1:0];
            if (wr_period) step_period <= wr_merged[PERIOD_WIDTH-1:0];

            if (cmd_abort) begin
                remaining <= '0;
            end else if (start) begin
                remaining <= count_val;
                timer     <= timer_reload;
            end else if (run_step) begin
                remaining <= remaining - COUNT_WIDTH'(1);
                timer     <= timer_reload;
            end else if (busy) begin
                timer <= timer - PERIOD_WIDTH'(1);
            end

            // Completion outranks a coincident clear.
            if (finish) begin
                done <= 1'b1;
            end else if (cmd_clr_done) begin
                done <= 1'b0;
            end

            if (wr_pos) begin
                position <= wr_merged[POS_WIDTH-1:0];
            end else if (step) begin
                position <= ctrl[CTRL_DIR] ? position + POS_WIDTH'(1)
                                           : position - POS_WIDTH'(1);
            end

            if (avs_ctrl_read) avs_ctrl_readdata <= rd_word;
        end
    end

    always_comb begin
        rd_word = '0;
        case (avs_ctrl_address)
            ADDR_PWM_FREQ:    rd_word[PWM_WIDTH-1:0]    = pwm_freq;
            ADDR_PWM_DUTY:    rd_word[PWM_WIDTH-1:0]    = pwm_duty;
            ADDR_CTRL:        rd_word[CTRL_W-1:0]       = ctrl;
            ADDR_STEP_PERIOD: rd_word[PERIOD_WIDTH-1:0] = step_period;
            ADDR_STEP_COUNT:  rd_word[COUNT_WIDTH-1:0]  = remaining;
            ADDR_STATUS: begin
                rd_word[STATUS_BUSY]           = busy;
                rd_word[STATUS_DONE]           = done;
                rd_word[STATUS_IDX_LSB +: 3]   = phase_idx;
            end
            ADDR_POSITION:    rd_word[POS_WIDTH-1:0]    = position;
            default:          rd_word = '0;
        endcase
    end

    stepper_phase_seq u_phase_seq (
        .clk       (csi_MCLK_clk),
        .reset     (rsi_MRST_reset),
        .step      (step),
        .dir       (ctrl[CTRL_DIR]),
        .half_step (ctrl[CTRL_HALF]),
        .idx       (phase_idx),
        .ax        (AX),
        .ay        (AY),
        .bx        (BX),
        .by        (BY)
    );

    assign avs_ctrl_waitrequest = 1'b0;
    assign ins_irq_irq          = done & ctrl[CTRL_IRQ_EN];
    assign AE                   = ~(pwm_on & ctrl[CTRL_DRV_EN] & (busy | ctrl[CTRL_HOLD]));
    assign BE                   = AE;

endmodule

// File: tb/tb_stepper_motion_ctrl.sv
// tb/tb_stepper_motion_ctrl.sv - self-checking bench for stepper_motion_ctrl
module tb_stepper_motion_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        irq;
    logic        ax, ay, bx, by, ae, be;

    int checks = 0;
    int errors = 0;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                            4'b0100, 4'b0101, 4'b0001, 4'b1001};

    stepper_motion_ctrl dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_address     (address),
        .avs_ctrl_write       (write),
        .avs_ctrl_read        (read),
        .avs_ctrl_writedata   (writedata),
        .avs_ctrl_byteenable  (byteenable),
        .avs_ctrl_readdata    (readdata),
        .avs_ctrl_waitrequest (waitrequest),
        .ins_irq_irq          (irq),
        .AX                   (ax),
        .AY                   (ay),
        .BX                   (bx),
        .BY                   (by),
        .AE                   (ae),
        .BE                   (be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_adv(input int idx, input bit dir, input bit half);
        int d;
        d = (half || (idx % 2 == 0)) ? 1 : 2;
        return dir ? (idx + d) % 8 : (idx + 8 - d) % 8;
    endfunction

    function automatic logic [3:0] exp_pins(input int idx);
        logic [3:0] v;
        v = tbl[idx];
        return ~v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; write = 1'b0; read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] bm);
        address = a; writedata = d; byteenable = bm; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic check_pins(input string name, input int idx);
        checks++;
        if ({by, bx, ay, ax} !== exp_pins(idx)) begin
            errors++;
            $display("FAIL %s pins: got %b expected %b", name, {by, bx, ay, ax}, exp_pins(idx));
        end
    endtask

    // Runs one move and checks pins, enable (busy) and irq (done) every cycle from a rate model.
    task automatic check_move(input string name, input int p, input int n, input bit dir,
                              input bit half, inout int idx, inout int pos);
        int pe, total, steps, cur;
        int exp_idx [$];
        logic [31:0] rd;
        pe = (p == 0) ? 1 : p;
        total = n * pe;
        cur = idx;
        exp_idx.push_back(cur);
        for (int s = 0; s < n; s++) begin
            cur = model_adv(cur, dir, half);
            exp_idx.push_back(cur);
        end
        bus_write(3'd2, 32'h14 | (32'(half) << 1) | 32'(dir), 4'hF);
        bus_write(3'd3, 32'(p), 4'hF);
        bus_write(3'd6, 32'h2, 4'hF);
        bus_write(3'd4, 32'(n), 4'hF);
        for (int k = 1; k <= total + 3; k++) begin
            if (k > 1) @(negedge clk);
            steps = (k - 1) / pe;
            if (steps > n) steps = n;
            check_pins(name, exp_idx[steps]);
            checks++;
            if (ae !== (k > total)) begin
                errors++;
                $display("FAIL %s AE cycle %0d: got %b expected %b", name, k, ae, (k > total));
            end
            checks++;
            if (irq !== (k > total)) begin
                errors++;
                $display("FAIL %s irq cycle %0d: got %b expected %b", name, k, irq, (k > total));
            end
        end
        pos = pos + (dir ? n : -n);
        idx = cur;
        bus_read(3'd7, rd);
        checks++;
        if (rd !== 32'(pos)) begin
            errors++;
            $display("FAIL %s position: got %h expected %h", name, rd, 32'(pos));
        end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== (32'(idx) << 4 | 32'h2)) begin
            errors++;
            $display("FAIL %s status: got %h expected %h", name, rd, (32'(idx) << 4 | 32'h2));
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [31:0] rd;
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL %s reg %0d: got %h expected 00000000", name, a, rd);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_pins("reset", 0);
        checks++;
        if ({ae, be, irq, waitrequest} !== 4'b1100) begin
            errors++;
            $display("FAIL reset ae/be/irq/wait: got %b expected 1100", {ae, be, irq, waitrequest});
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset readdata: got %h expected 0", readdata);
        end
        check_all_zero("reset_regs");
    endtask

    task automatic test_timed_move();
        int idx = 0, pos = 0;
        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        check_move("timed_move", 4, 3, 1'b1, 1'b1, idx, pos);
    endtask

    task automatic test_full_step();
        int idx = 0, pos = 0;
        logic [31:0] rd;
        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h14, 4'hF);
        for (int i = 0; i < 3; i++) begin
            bus_write(3'd6, 32'h4, 4'hF);
            idx = model_adv(idx, 1'b0, 1'b0);
            pos = pos - 1;
            check_pins("single_step", idx);
        end
        checks++;
        if (idx != 3 || irq !== 1'b0) begin
            errors++;
            $display("FAIL single_step idx/irq: got %0d/%b expected 3/0", idx, irq);
        end
        bus_read(3'd7, rd);
        checks++;
        if (rd !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL single_step position: got %h expected FFFFFFFD", rd);
        end
        check_move("p0_move", 0, 5, 1'b0, 1'b0, idx, pos);
    endtask

    task automatic test_pwm();
        logic s [8];
        int lows;
        do_reset();
        bus_write(3'd0, 32'h4000_0000, 4'hF);
        bus_write(3'd1, 32'h7FFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h0C, 4'hF);
        @(negedge clk);
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s[i] = ae;
            if (ae === 1'b0) lows++;
            checks++;
            if (be !== ae) begin
                errors++;
                $display("FAIL pwm be: got %b expected %b", be, ae);
            end
        end
        checks++;
        if (lows != 4) begin
            errors++;
            $display("FAIL pwm half duty lows: got %0d expected 4", lows);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (s[i] !== s[i+4]) begin
                errors++;
                $display("FAIL pwm period %0d: got %b expected %b", i, s[i+4], s[i]);
            end
        end
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (ae !== 1'b0) begin
                errors++;
                $display("FAIL pwm full duty cycle %0d: got %b expected 0", i, ae);
            end
        end
    endtask

    task automatic start_p3(input logic [31:0] n);
        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h17, 4'hF);
        bus_write(3'd3, 32'd3, 4'hF);
        bus_write(3'd4, n, 4'hF);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_collisions();
        logic [31:0] rd;
        start_p3(32'd5);
        bus_write(3'd6, 32'h1, 4'hF);
        check_pins("abort_on_step", 0);
        checks++;
        if ({ae, irq} !== 2'b10) begin
            errors++;
            $display("FAIL abort_on_step ae/irq: got %b expected 10", {ae, irq});
        end
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++;
            $display("FAIL abort_on_step remaining: got %h expected 0", rd);
        end

        start_p3(32'd5);
        bus_write(3'd4, 32'd7, 4'hF);
        bus_read(3'd4, rd);
        checks++;
        if (rd !== 32'd7) begin
            errors++;
            $display("FAIL rewrite remaining: got %h expected 7", rd);
        end
        check_pins("rewrite_suppress", 0);

        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h17, 4'hF);
        bus_write(3'd3, 32'd2, 4'hF);
        bus_write(3'd4, 32'd1, 4'hF);
        @(negedge clk);
        bus_write(3'd6, 32'h2, 4'hF);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL clr_done_vs_finish irq: got %b expected 1", irq);
        end
        bus_read(3'd5, rd);
        checks++;
        if (rd !== 32'h12) begin
            errors++;
            $display("FAIL clr_done_vs_finish status: got %h expected 00000012", rd);
        end
        bus_write(3'd6, 32'h2, 4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL clr_done irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_reset_and_byteenable();
        logic [31:0] rd;
        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        bus_write(3'd2, 32'h17, 4'hF);
        bus_write(3'd3, 32'd2, 4'hF);
        bus_write(3'd4, 32'd100, 4'hF);
        repeat (20) @(negedge clk);
        do_reset();
        check_pins("mid_reset", 0);
        checks++;
        if ({ae, irq} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset ae/irq: got %b expected 10", {ae, irq});
        end
        check_all_zero("mid_reset_regs");
        bus_write(3'd1, 32'hAABB_CCDD, 4'b0101);
        bus_read(3'd1, rd);
        checks++;
        if (rd !== 32'h00BB_00DD) begin
            errors++;
            $display("FAIL byteenable duty: got %h expected 00BB00DD", rd);
        end
    endtask

    task automatic test_random_moves();
        int idx = 0, pos = 0;
        logic [31:0] wd, merged, rd;
        logic [3:0] bm;
        do_reset();
        bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
        for (int it = 0; it < 8; it++) begin
            wd = $urandom;
            bm = 4'($urandom_range(0, 15));
            merged = 32'(pos);
            for (int b = 0; b < 4; b++) if (bm[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
            bus_write(3'd7, wd, bm);
            pos = int'(merged);
            bus_read(3'd7, rd);
            checks++;
            if (rd !== merged) begin
                errors++;
                $display("FAIL random pos write: got %h expected %h", rd, merged);
            end
            check_move("random_move", int'($urandom_range(0, 5)), int'($urandom_range(1, 6)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), idx, pos);
        end
    endtask

    initial begin
        rst = 1'b1; address = '0; write = 1'b0; read = 1'b0;
        writedata = '0; byteenable = '0;
        test_reset();
        test_timed_move();
        test_full_step();
        test_pwm();
        test_collisions();
        test_reset_and_byteenable();
        test_random_moves();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
